// File: rtl/nand_adder_pkg.sv
// Shared definitions for the NAND-cell serial adder: state encoding and counter sizing.
// Latency: n/a (compile-time constants and a constant function only).
// Backpressure: n/a.
package nand_adder_pkg;

  // Controller state encoding, shared with anything that decodes the state.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Width of the step counter: clog2(width/step), never narrower than one bit
  // so that a single-step configuration still has a legal vector.
  function automatic int cnt_width(input int width, input int step);
    int steps;
    steps = width / step;
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/nand_serial_adder_fa_nand_cell.sv
// One-bit full adder built purely from nine two-input NAND gates.
// Latency: combinational, no state.
// Backpressure: none; pure function of a, b and ci.
module fa_nand_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic n_ab;   // ~(a & b)
  logic n_a;    // ~(a & n_ab)
  logic n_b;    // ~(b & n_ab)
  logic x_ab;   // a ^ b
  logic n_xc;   // ~(x_ab & ci)
  logic n_x;    // ~(x_ab & n_xc)
  logic n_c;    // ~(ci & n_xc)

  // First half adder: x_ab = a ^ b, n_ab doubles as the generate term.
  nand u_g1 (n_ab, a, b);
  nand u_g2 (n_a, a, n_ab);
  nand u_g3 (n_b, b, n_ab);
  nand u_g4 (x_ab, n_a, n_b);

  // Second half adder: s = x_ab ^ ci, n_xc doubles as the propagate-carry term.
  nand u_g5 (n_xc, x_ab, ci);
  nand u_g6 (n_x, x_ab, n_xc);
  nand u_g7 (n_c, ci, n_xc);
  nand u_g8 (s, n_x, n_c);

  // Carry out = (a & b) | ((a ^ b) & ci), which is NAND of the two inverted terms.
  nand u_g9 (co, n_ab, n_xc);

endmodule

// File: rtl/nand_serial_adder.sv
// Serial add/subtract of two WIDTH-bit operands, STEP bits per clock through a NAND full-adder chain.
// Latency: operands accepted at edge N give out_valid from edge N + WIDTH/STEP.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready is seen at an edge.
module nand_serial_adder
  import nand_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            NSTEPS   = WIDTH / STEP;
  localparam int            CW       = cnt_width(WIDTH, STEP);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSTEPS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Ripple chain for one step: chain_c[0] is the registered carry,
  // chain_c[STEP] is the carry leaving the chunk.
  logic [STEP:0]    chain_c;
  logic [STEP-1:0]  chain_s;

  assign chain_c[0] = c_q;

  for (genvar i = 0; i < STEP; i++) begin : g_cell
    fa_nand_cell u_cell (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (chain_c[i]),
      .s  (chain_s[i]),
      .co (chain_c[i+1])
    );
  end

  // Next-state, datapath shifting and result capture; every _d defaults to hold.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B on entry and force the carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // New sum bits enter from the MSB side so that after NSTEPS shifts
        // the first chunk computed has reached bit 0.
        sum_d = (sum_q >> STEP) | (WIDTH'(chain_s) << (WIDTH - STEP));
        a_d   = a_q >> STEP;
        b_d   = b_q >> STEP;
        c_d   = chain_c[STEP];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // On the last chunk the top cell is operand bit WIDTH-1, so the
          // carry into it is the one feeding the last cell of the chain.
          cout_d  = chain_c[STEP];
          ovf_d   = chain_c[STEP] ^ chain_c[STEP-1];
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode only the state register, so nothing combinational
  // reaches them from in_valid or out_ready.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nand_serial_adder.sv
// Bench for nand_serial_adder: several WIDTH/STEP instances run side by side.
// Each instance: reset checks, directed vectors with latency/backpressure, reset mid-run, random traffic.
// A reference model per instance predicts handshakes and results every cycle.
module tb_nand_serial_adder;

  localparam int NCFG   = 6;
  localparam int N_RAND = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_done = 0;

  function automatic int cfg_w(input int k);
    case (k)
      0: return 8;
      1: return 8;
      2: return 16;
      3: return 8;
      4: return 8;
      default: return 12;
    endcase
  endfunction

  function automatic int cfg_s(input int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 16;
      3: return 2;
      4: return 8;
      default: return 3;
    endcase
  endfunction

  typedef struct packed {
    int          w;
    int          s;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
  } dvec_t;

  localparam int NDIR = 7;

  // Hand-computed directed vectors with their exact expected results.
  function automatic dvec_t dvec(input int i);
    case (i)
      0: return '{8,  1,  16'h005A, 16'h0033, 1'b1, 1'b0, 16'h008E, 1'b0, 1'b1};
      1: return '{8,  4,  16'h0010, 16'h0020, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0};
      2: return '{8,  4,  16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1};
      3: return '{16, 16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      4: return '{8,  2,  16'h00FF, 16'h00FF, 1'b1, 1'b0, 16'h00FF, 1'b1, 1'b0};
      5: return '{8,  8,  16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      default: return '{12, 3, 16'h07FF, 16'h0001, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b1};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  for (genvar k = 0; k < NCFG; k++) begin : g
    localparam int W = cfg_w(k);
    localparam int S = cfg_s(k);
    localparam int L = W / S;

    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    nand_serial_adder #(.WIDTH(W), .STEP(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
    } res_t;

    function automatic string nm(input string s);
      return $sformatf("cfg%0d(W%0d,S%0d).%s", k, W, S, s);
    endfunction

    // Plain arithmetic: W+1-bit sum, signed overflow from operand/result signs.
    function automatic res_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
      logic [W-1:0] yy;
      logic [W:0]   full;
      res_t         r;
      yy   = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
      r.s  = full[W-1:0];
      r.c  = full[W];
      r.o  = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
      return r;
    endfunction

    res_t q[$];
    int   cnt     = 0;
    bit   mvld    = 1'b0;
    bit   started = 1'b0;
    bit   rflag   = 1'b0;

    // Transaction-level model: busy for L cycles after acceptance, then holds a result.
    always @(posedge clk) begin
      started = 1'b1;
      if (!rst_n) begin
        cnt   = 0;
        mvld  = 1'b0;
        rflag = 1'b1;
        q.delete();
      end else if (mvld) begin
        if (out_ready) begin
          mvld = 1'b0;
          if (q.size() > 0) void'(q.pop_front());
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mvld = 1'b1;
      end else if (in_valid) begin
        q.push_back(ref_model(a, b, cin, sub));
        cnt   = L;
        rflag = 1'b0;
      end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
      if (started) begin
        chk(nm("in_ready"), 32'(in_ready), 32'(!mvld && cnt == 0));
        chk(nm("out_valid"), 32'(out_valid), 32'(mvld));
        if (mvld && q.size() > 0) begin
          chk(nm("sum"), 32'(sum), 32'(q[0].s));
          chk(nm("cout"), 32'(cout), 32'(q[0].c));
          chk(nm("ovf"), 32'(ovf), 32'(q[0].o));
        end
        if (rflag) begin
          chk(nm("rst_sum"), 32'(sum), 32'(0));
          chk(nm("rst_cout"), 32'(cout), 32'(0));
          chk(nm("rst_ovf"), 32'(ovf), 32'(0));
        end
      end
    end

    // Single transaction with literal expectations, exact latency and a 5-cycle stall in DONE.
    task automatic run_vec(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                           input logic sb, input logic [15:0] es, input logic ec,
                           input logic eo, input string tag);
      logic [W-1:0] es_w;
      int guard;
      int lat;
      es_w      = es[W-1:0];
      a         = av[W-1:0];
      b         = bv[W-1:0];
      cin       = ci;
      sub       = sb;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      guard     = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      chk(nm({tag, "_accept"}), 32'(in_ready), 32'(1));
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin
        @(negedge clk);
        lat++;
      end
      chk(nm({tag, "_latency"}), 32'(lat), 32'(L));
      chk(nm({tag, "_sum"}), 32'(sum), 32'(es_w));
      chk(nm({tag, "_cout"}), 32'(cout), 32'(ec));
      chk(nm({tag, "_ovf"}), 32'(ovf), 32'(eo));
      repeat (4) begin
        @(negedge clk);
        chk(nm({tag, "_hold_vld"}), 32'(out_valid), 32'(1));
        chk(nm({tag, "_hold_rdy"}), 32'(in_ready), 32'(0));
        chk(nm({tag, "_hold_sum"}), 32'(sum), 32'(es_w));
        chk(nm({tag, "_hold_cout"}), 32'(cout), 32'(ec));
        chk(nm({tag, "_hold_ovf"}), 32'(ovf), 32'(eo));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk(nm({tag, "_release_vld"}), 32'(out_valid), 32'(0));
      chk(nm({tag, "_release_rdy"}), 32'(in_ready), 32'(1));
    endtask

    initial begin
      dvec_t d;
      int    guard;
      int    sent;
      int    rk;
      bit    prev_rdy;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk(nm("reset_in_ready"), 32'(in_ready), 32'(1));
      chk(nm("reset_out_valid"), 32'(out_valid), 32'(0));
      chk(nm("reset_sum"), 32'(sum), 32'(0));
      chk(nm("reset_cout"), 32'(cout), 32'(0));
      chk(nm("reset_ovf"), 32'(ovf), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors that belong to this configuration.
      for (int i = 0; i < NDIR; i++) begin
        d = dvec(i);
        if (d.w == W && d.s == S)
          run_vec(d.a, d.b, d.cin, d.sub, d.es, d.ec, d.eo, $sformatf("dir%0d", i));
      end

      // Back-to-back pair under stall, second one must be clean.
      run_vec(16'h0055, 16'h0011, 1'b0, 1'b0, 16'h0066, 1'b0, 1'b0, "pair1");
      run_vec(16'h0001, 16'h0002, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "pair2");

      // Reset in the middle of a carry-heavy operation.
      a        = '1;
      b        = W'(1);
      cin      = 1'b1;
      sub      = 1'b0;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rk = (L - 1 < 2) ? L - 1 : 2;
      repeat (rk) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk(nm("midrst_out_valid"), 32'(out_valid), 32'(0));
      chk(nm("midrst_in_ready"), 32'(in_ready), 32'(1));
      chk(nm("midrst_sum"), 32'(sum), 32'(0));
      run_vec(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, "post_rst");

      // Random traffic; the model/compare process does the checking.
      sent     = 0;
      prev_rdy = 1'b0;
      guard    = 0;
      while ((sent < N_RAND || mvld || cnt != 0 || in_valid) && guard < 80000) begin
        @(negedge clk);
        guard++;
        if (in_valid && prev_rdy) begin
          in_valid = 1'b0;
          sent++;
        end
        out_ready = 1'($urandom_range(0, 1));
        if (!in_valid && sent < N_RAND && $urandom_range(0, 2) != 0) begin
          a        = W'($urandom);
          b        = W'($urandom);
          cin      = 1'($urandom_range(0, 1));
          sub      = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
        end
        prev_rdy = in_ready;
      end
      out_ready = 1'b0;
      chk(nm("rand_sent"), 32'(sent), 32'(N_RAND));
      chk(nm("rand_drained"), 32'(q.size()), 32'(0));
      n_done++;
    end
  end

  initial begin
    int c;
    c = 0;
    while (n_done < NCFG && c < 95000) begin
      @(posedge clk);
      c++;
    end
    if (n_done < NCFG) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: %0d of %0d configurations finished", n_done, NCFG);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
